// File: rtl/ram_access_ctrl.sv
// Initiator-side burst controller for a byte-wide RAM: sequences address, write strobe and
// read-latency timing per beat, and returns read bytes on a registered valid strobe.
module ram_access_ctrl #(
  parameter int AW     = 1,
  parameter int LW     = 2,
  parameter int RD_LAT = 1
) (
  input  logic          CLK_,
  input  logic          RST_,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic          REQ_WR,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [LW-1:0] REQ_LEN,
  input  logic          WR_VALID,
  output logic          WR_READY,
  input  logic [7:0]    WR_DATA,
  output logic          RD_VALID,
  output logic [7:0]    RD_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          RAM_R_W_,
  output logic [AW-1:0] RAM_ADDR_,
  output logic [7:0]    RAM_DATA_IN,
  input  logic [7:0]    RAM_DATA_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0]    LAT_RELOAD = 2'(RD_LAT - 1);
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
  localparam logic [LW-1:0] BEAT_ONE   = LW'(1);
  localparam logic [LW-1:0] BEAT_ZERO  = LW'(0);

  state_t        state_r, state_s;
  logic [LW-1:0] beat_r, beat_s;
  logic [1:0]    lat_r, lat_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [7:0]    rd_data_r, rd_data_s;
  logic          rd_valid_r, rd_valid_s;
  logic          req_ready_r, busy_r, done_r, wr_ready_r;

  // Next-state and datapath decisions for the burst sequencer
  always_comb begin
    state_s    = state_r;
    beat_s     = beat_r;
    lat_s      = lat_r;
    addr_s     = addr_r;
    rd_data_s  = rd_data_r;
    rd_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (REQ_VALID) begin
          addr_s  = REQ_ADDR;
          beat_s  = REQ_LEN;
          lat_s   = LAT_RELOAD;
          state_s = REQ_WR ? ST_WRITE : ST_READ;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        // A stalled beat keeps address and counter untouched.
        if (WR_VALID) begin
          addr_s = addr_r + ADDR_ONE;
          if (beat_r == BEAT_ZERO) begin
            state_s = ST_DONE;
          end else begin
            beat_s = beat_r - BEAT_ONE;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (lat_r == 2'd0) begin
          rd_data_s  = RAM_DATA_OUT;
          rd_valid_s = 1'b1;
          addr_s     = addr_r + ADDR_ONE;
          lat_s      = LAT_RELOAD;
          if (beat_r == BEAT_ZERO) begin
            state_s = ST_DONE;
          end else begin
            beat_s = beat_r - BEAT_ONE;
          end
        end else begin
          lat_s = lat_r - 2'd1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status flags; reset abandons any burst in flight
  always_ff @(posedge CLK_) begin
    if (RST_) begin
      state_r     <= ST_IDLE;
      beat_r      <= BEAT_ZERO;
      lat_r       <= 2'd0;
      addr_r      <= {AW{1'b0}};
      rd_data_r   <= 8'h00;
      rd_valid_r  <= 1'b0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      wr_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      beat_r      <= beat_s;
      lat_r       <= lat_s;
      addr_r      <= addr_s;
      rd_data_r   <= rd_data_s;
      rd_valid_r  <= rd_valid_s;
      req_ready_r <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= (state_s == ST_DONE);
      wr_ready_r  <= (state_s == ST_WRITE);
    end
  end

  assign REQ_READY   = req_ready_r;
  assign BUSY        = busy_r;
  assign DONE        = done_r;
  assign WR_READY    = wr_ready_r;
  assign RD_VALID    = rd_valid_r;
  assign RD_DATA     = rd_data_r;
  assign RAM_ADDR_   = addr_r;
  assign RAM_DATA_IN = WR_DATA;
  // The write strobe is gated by reset so the reset edge can never write.
  assign RAM_R_W_    = wr_ready_r & WR_VALID & ~RST_;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: two lanes (RD_LAT=1 and RD_LAT=3), each with a behavioural RAM,
// a cycle-level expectation model checked every cycle, and directed tests with literal checks.
module tb_ram_access_ctrl;
  localparam int AW = 1;
  localparam int LW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit [1:0] lane_done = 2'b00;

  function automatic void chk(int ln, string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL lane%0d %s: got %0h expected %0h", ln, nm, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic          rst = 1'b1, req_valid = 1'b0, req_wr = 1'b0, wr_valid = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic [7:0]    wr_data = 8'h00;
    logic          req_ready, wr_ready, rd_valid, busy, done, ram_r_w;
    logic [7:0]    rd_data, ram_data_in, ram_data_out;
    logic [AW-1:0] ram_addr;

    ram_access_ctrl #(.AW(AW), .LW(LW), .RD_LAT(LAT)) u_dut (
      .CLK_(clk), .RST_(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
      .REQ_WR(req_wr), .REQ_ADDR(req_addr), .REQ_LEN(req_len),
      .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_DATA(wr_data),
      .RD_VALID(rd_valid), .RD_DATA(rd_data), .BUSY(busy), .DONE(done),
      .RAM_R_W_(ram_r_w), .RAM_ADDR_(ram_addr), .RAM_DATA_IN(ram_data_in),
      .RAM_DATA_OUT(ram_data_out)
    );

    // Behavioural RAM: write at the rising edge, read data appears LAT cycles after address.
    logic [7:0] mem [2**AW] = '{default: 8'h00};
    logic [7:0] pipe [3] = '{default: 8'h00};
    always @(posedge clk) begin
      if (ram_r_w) mem[ram_addr] <= ram_data_in;
      pipe[0] <= mem[ram_addr];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign ram_data_out = (LAT == 1) ? mem[ram_addr] : pipe[(LAT >= 2) ? LAT - 2 : 0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation model: beats left, cycles until next read capture, expected address/data.
    int            wr_left = 0, rd_left = 0, rd_wait = 0, n_wr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_rd = 8'h00, d;
    logic [7:0]    m_mem [2**AW] = '{default: 8'h00};
    bit            rv_due = 0, done_due = 0, armed = 0, rv_n, done_n, busy_e;
    logic [7:0]    wr_q [$];
    int            acc_q [$], done_q [$], strobe_q [$];
    logic [7:0]    strobe_d [$];

    always @(negedge clk) begin
      if (armed) begin
        busy_e = (wr_left > 0) || (rd_left > 0) || done_due;
        chk(g, "busy", busy, busy_e);
        chk(g, "req_ready", req_ready, !busy_e);
        chk(g, "wr_ready", wr_ready, wr_left > 0);
        chk(g, "rd_valid", rd_valid, rv_due);
        chk(g, "rd_data", rd_data, m_rd);
        chk(g, "done", done, done_due);
        chk(g, "ram_addr", ram_addr, m_addr);
        chk(g, "ram_r_w", ram_r_w, !rst && (wr_left > 0) && wr_valid);
        if (rd_valid) begin
          strobe_q.push_back(cyc);
          strobe_d.push_back(rd_data);
        end
        if (done) done_q.push_back(cyc);
      end
      if (ram_r_w) n_wr++;
      rv_n = 0;
      done_n = 0;
      if (rst) begin
        armed = 1; wr_left = 0; rd_left = 0; rd_wait = 0;
        m_addr = '0; m_rd = 8'h00; wr_q.delete();
      end else if (wr_left > 0) begin
        if (wr_valid) begin
          d = wr_q.pop_front();
          chk(g, "ram_data_in", ram_data_in, d);
          m_mem[m_addr] = d;
          m_addr = m_addr + 1'b1;
          wr_left--;
          done_n = (wr_left == 0);
        end
      end else if (rd_left > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          m_rd = m_mem[m_addr];
          rv_n = 1;
          m_addr = m_addr + 1'b1;
          rd_left--;
          rd_wait = LAT;
          done_n = (rd_left == 0);
        end
      end else if (!done_due && req_valid) begin
        acc_q.push_back(cyc);
        m_addr = req_addr;
        if (req_wr) wr_left = int'(req_len) + 1;
        else begin
          rd_left = int'(req_len) + 1;
          rd_wait = LAT;
        end
      end
      rv_due = rv_n;
      done_due = done_n;
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic clr();
      acc_q.delete(); done_q.delete(); strobe_q.delete(); strobe_d.delete(); n_wr = 0;
    endtask

    task automatic wait_idle();
      int k = 0;
      while (busy && k < 80) begin tick(); k++; end
      chk(g, "idle_timeout", busy, 1'b0);
    endtask

    task automatic issue(bit wr, logic [AW-1:0] a, logic [LW-1:0] l);
      int k = 0;
      while (!req_ready && k < 50) begin tick(); k++; end
      chk(g, "ready_timeout", req_ready, 1'b1);
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_len = l;
      tick();
      req_valid = 1'b0;
    endtask

    task automatic wr_burst(logic [AW-1:0] a, int n, logic [15:0] bytes, int stall);
      for (int i = 0; i < n; i++) wr_q.push_back((i == 0) ? bytes[7:0] : bytes[15:8]);
      issue(1'b1, a, LW'(n - 1));
      for (int i = 0; i < n; i++) begin
        if (i == 1) begin
          wr_valid = 1'b0;
          repeat (stall) tick();
        end
        wr_valid = 1'b1;
        wr_data = (i == 0) ? bytes[7:0] : bytes[15:8];
        tick();
      end
      wr_valid = 1'b0;
      wait_idle();
    endtask

    task automatic rd_burst(logic [AW-1:0] a, int n);
      issue(1'b0, a, LW'(n - 1));
      wait_idle();
    endtask

    initial begin
      int k;
      // T1 reset
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      chk(g, "t1_busy", busy, 1'b0);
      chk(g, "t1_req_ready", req_ready, 1'b1);
      chk(g, "t1_rd_valid", rd_valid, 1'b0);
      chk(g, "t1_done", done, 1'b0);
      chk(g, "t1_ram_r_w", ram_r_w, 1'b0);
      chk(g, "t1_ram_addr", ram_addr, 1'b0);
      // T2 single write then read
      clr();
      wr_burst(1'b0, 1, 16'h00AA, 0);
      chk(g, "t2_done_cnt", done_q.size(), 1);
      chk(g, "t2_done_lat", done_q[0] - acc_q[0], 2);
      chk(g, "t2_mem0", mem[0], 8'hAA);
      clr();
      rd_burst(1'b0, 1);
      chk(g, "t2_rd_cnt", strobe_q.size(), 1);
      chk(g, "t2_rd_data", strobe_d[0], 8'hAA);
      chk(g, "t2_rd_lat", strobe_q[0] - acc_q[0], LAT + 1);
      chk(g, "t2_done_with_rd", done_q[0], strobe_q[0]);
      // T3 wrap burst
      clr();
      wr_burst(1'b1, 2, 16'h2211, 0);
      chk(g, "t3_mem1", mem[1], 8'h11);
      chk(g, "t3_mem0", mem[0], 8'h22);
      clr();
      rd_burst(1'b1, 2);
      chk(g, "t3_rd_cnt", strobe_q.size(), 2);
      chk(g, "t3_rd0", strobe_d[0], 8'h11);
      chk(g, "t3_rd1", strobe_d[1], 8'h22);
      chk(g, "t3_cadence", strobe_q[1] - strobe_q[0], LAT);
      chk(g, "t3_done_with_rd", done_q[0], strobe_q[1]);
      // T4 write stall
      clr();
      wr_burst(1'b0, 2, 16'hC35A, 3);
      chk(g, "t4_mem0", mem[0], 8'h5A);
      chk(g, "t4_mem1", mem[1], 8'hC3);
      chk(g, "t4_done_cnt", done_q.size(), 1);
      chk(g, "t4_done_lat", done_q[0] - acc_q[0], 6);
      chk(g, "t4_writes", n_wr, 2);
      // T5 request held during a burst
      clr();
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 1'b1; req_len = 2'd1;
      k = 0;
      while (acc_q.size() < 2 && k < 60) begin tick(); k++; end
      req_valid = 1'b0;
      wait_idle();
      chk(g, "t5_acc_cnt", acc_q.size(), 2);
      chk(g, "t5_reaccept", acc_q[1], done_q[0] + 1);
      chk(g, "t5_rd_cnt", strobe_q.size(), 4);
      chk(g, "t5_rd2", strobe_d[2], 8'hC3);
      // T6 reset mid-read
      clr();
      issue(1'b0, 1'b0, 2'd3);
      k = 0;
      while (!rd_valid && k < 50) begin tick(); k++; end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk(g, "t6_idle", busy, 1'b0);
      repeat (8) tick();
      chk(g, "t6_rd_cnt", strobe_q.size(), 1);
      chk(g, "t6_done_cnt", done_q.size(), 0);
      chk(g, "t6_writes", n_wr, 0);
      lane_done[g] = 1'b1;
    end
  end

  initial begin
    int k = 0;
    while (lane_done != 2'b11 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    chk(9, "lanes_finished", lane_done, 2'b11);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
